// File: rtl/instr_assembler.sv
// instr_assembler: packs R/I/J instruction fields into 32-bit words and
// queues them in a DEPTH-entry FIFO. Each emitted word is tagged with a byte
// address that starts at BASE_ADDR and advances by 4 per output handshake.
// A tuple with the reserved format (fmt=11) is accepted and dropped, and it
// sets the sticky err flag.
// Optional feature macro: INSTR_ASM_BYPASS_EN. When it is defined and the FIFO
// is empty, a valid input word is presented on the output in the same cycle.
module instr_assembler #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Field packing by format; the reserved format produces an all-zero word
  // that is never stored.
  function automatic logic [31:0] pack_word(
    input logic [1:0]  f,
    input logic [5:0]  op,
    input logic [4:0]  s,
    input logic [4:0]  t,
    input logic [4:0]  d,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [15:0] i16,
    input logic [25:0] i26
  );
    logic [31:0] w;
    case (f)
      2'b00:   w = {op, s, t, d, sh, fn};
      2'b01:   w = {op, s, t, i16};
      2'b10:   w = {op, i26};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        full;
  logic        empty;
  logic        reserved;
  logic        in_fire;
  logic        out_fire;
  logic        push;
  logic        pop;
  logic [31:0] packed_word;

  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign reserved    = (fmt == 2'b11);
  assign packed_word = pack_word(fmt, opcode, rs, rt, rd, shamt, func, imm16, imm26);
  assign in_ready    = !full;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;

`ifdef INSTR_ASM_BYPASS_EN
  logic bypass_act;

  // With an empty FIFO a valid word goes straight to the output; it is only
  // queued when the sink is not ready to take it this cycle.
  always_comb begin
    bypass_act = empty && in_valid && !reserved;
    out_valid  = !empty || bypass_act;
    out_instr  = 32'h0000_0000;
    if (!empty) begin
      out_instr = mem[rd_ptr];
    end else if (bypass_act) begin
      out_instr = packed_word;
    end
    pop  = out_fire && !empty;
    push = in_fire && !reserved && !(bypass_act && out_ready);
  end
`else
  // Registered-only output: the head of the FIFO, zero while empty.
  always_comb begin
    out_valid = !empty;
    out_instr = empty ? 32'h0000_0000 : mem[rd_ptr];
    pop       = out_fire;
    push      = in_fire && !reserved;
  end
`endif

  // Storage array; contents are meaningless outside the occupied range so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= packed_word;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

  // Output address advances one word per completed output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_addr <= BASE_ADDR;
    end else if (out_fire) begin
      out_addr <= out_addr + 32'd4;
    end
  end

  // Sticky flag for accepted reserved-format tuples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (in_fire && reserved) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_3000, address tagged to the first emitted word.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  field tuple valid.
REQ-006 SHALL have port in_ready  output  1  tuple accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port fmt  input  2  00 R-type, 01 I-type, 10 J-type, 11 reserved.
REQ-008 SHALL have ports opcode/rs/rt/rd/shamt/func/imm16/imm26  input  6/5/5/5/5/6/16/26  instruction fields.
REQ-009 SHALL have port out_valid  output  1  out_instr valid.
REQ-010 SHALL have port out_ready  input  1  sink accepts when out_valid && out_ready at a rising edge.
REQ-011 SHALL have port out_instr  output  32  packed instruction word.
REQ-012 SHALL have port out_addr  output  32  byte address of out_instr.
REQ-013 SHALL have port err  output  1  sticky reserved-format flag.

Function
REQ-014 SHALL pack R as {opcode,rs,rt,rd,shamt,func}, I as {opcode,rs,rt,imm16}, J as {opcode,imm26}; unused fields ignored.
REQ-015 SHALL buffer packed words in a DEPTH-entry FIFO with wrap-around read/write pointers and an occupancy count 0..DEPTH.
REQ-016 SHALL drive in_ready = !full, independent of out_ready (no push while full, even with a simultaneous pop).
REQ-017 SHALL drive out_valid = !empty and out_instr = FIFO head; a word pushed at edge N is presented after edge N (one-cycle latency).
REQ-018 SHALL keep out_instr and out_addr stable while out_valid && !out_ready.
REQ-019 SHALL, on simultaneous push and pop when neither full nor empty, keep occupancy unchanged.
REQ-020 SHALL accept a fmt=11 tuple (handshake completes), not enqueue it, and set err to 1 at that edge.
REQ-021 SHALL advance out_addr by 4 on each output handshake, wrapping modulo 2^32.
REQ-022 SHALL hold err at 1 until reset.

Reset
REQ-023 SHALL, on reset low, immediately (asynchronously) empty the FIFO, discarding held words.
REQ-024 SHALL reset to out_valid=0, in_ready=1, out_instr=0, out_addr=BASE_ADDR, err=0.
REQ-025 SHALL, if reset asserts mid-handshake, complete no transfer at that edge.

Configuration
REQ-026 SHALL support macro INSTR_ASM_BYPASS_EN.
REQ-027 SHALL, with INSTR_ASM_BYPASS_EN defined and the FIFO empty, present a valid non-reserved input combinationally (out_valid=1, out_instr=packed input, out_addr=current); on out_ready=1 the word is consumed without enqueue (zero latency).
REQ-028 SHALL, with INSTR_ASM_BYPASS_EN defined and the FIFO empty, drive in_ready=1; with out_ready=0 the input is enqueued normally.
REQ-029 SHALL, without INSTR_ASM_BYPASS_EN, have no combinational input-to-output path (REQ-017 latency only).

Verification
REQ-030 SHALL check R pack: fmt=00, opcode=0, rs=1, rt=2, rd=3, shamt=0, func=0x21, out_ready=1 -> out_instr=0x00221821, out_addr=0x00003000 one cycle later.
REQ-031 SHALL check I then J: ori (opcode 0x0D, rs=0, rt=1, imm16=0x1234) -> 0x34011234 @0x3000; j (opcode 2, imm26=0x0000C00) -> 0x08000C00 @0x3004.
REQ-032 SHALL check full: out_ready=0, push 5 tuples -> in_ready=0 after 4th push, 5th held; one pop -> in_ready=1, 5th accepted next edge, order preserved.
REQ-033 SHALL check reserved: fmt=11 pushed into an empty FIFO -> err=1, out_valid stays 0, out_addr stays 0x3000.
REQ-034 SHALL check reset mid-operation: 3 words queued, reset pulsed low -> out_valid=0, out_addr=0x3000, err=0; next push emits @0x3000.
REQ-035 SHALL check bypass (macro on): empty FIFO, in_valid=1, out_ready=1 -> out_instr equals packed input in the same cycle, occupancy remains 0.
